// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter.
// Sends one command byte to the device using the request-to-send handshake.
// The PS/2 clock and data lines are open-collector: ps2Co/ps2Do = 1 pulls the line low.
// Optional build macro PS2TX_RESEND_EN: retry a failed frame (NACK or timeout) up to
// RETRIES more times before reporting the error.
module ps2_host_tx #(
    parameter int INHIBIT = 800,    // ce ticks the clock is held low before request-to-send
    parameter int TIMEOUT = 16000,  // ce ticks allowed between device edges / for final idle
    parameter int RETRIES = 2       // extra attempts after an error (resend builds only)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2Ci,
    input  logic       ps2Di,
    output logic       ps2Co,
    output logic       ps2Do,
    input  logic       start,
    input  logic [7:0] di,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_MAX = (INHIBIT > TIMEOUT) ? INHIBIT : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIB,
        S_RTS,
        S_XFER,
        S_WAITIDLE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;      // inhibit length / watchdog
    logic [3:0]    bit_q, bit_d;      // device falling edges seen in this frame
    logic [8:0]    shift_q, shift_d;  // {parity, data}, shifted out LSB-first
    logic          co_q, co_d;
    logic          do_q, do_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fail;              // current attempt ended in NACK or timeout
    logic          can_retry;

    // Synchroniser: c_q[1]/d_q[1] are the synchronised lines, c_q[2] the previous clock.
    logic [2:0] c_q;
    logic [1:0] d_q;
    logic       c_s, d_s, fe;

    assign c_s = c_q[1];
    assign d_s = d_q[1];
    assign fe  = c_q[2] & ~c_q[1];

`ifdef PS2TX_RESEND_EN
    localparam int RW = $clog2(RETRIES + 2);
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    data_q, data_d;    // captured byte, reloaded on every retry

    assign can_retry = (retry_q < RW'(RETRIES));

    // Retry bookkeeping registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retry_q <= '0;
            data_q  <= '0;
        end else if (ce) begin
            retry_q <= retry_d;
            data_q  <= data_d;
        end
    end
`else
    // Single attempt per start; RETRIES has no effect in this build.
    assign can_retry = 1'b0 & (RETRIES != 0);
`endif

    // Two-stage line synchroniser plus edge history, idle-high out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_q <= '1;
            d_q <= '1;
        end else if (ce) begin
            c_q <= {c_q[1:0], ps2Ci};
            d_q <= {d_q[0], ps2Di};
        end
    end

    // FSM state, counters and registered line drivers.
    // NOTE: sequential state is only ever assigned with non-blocking (<=) assignments.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            co_q    <= 1'b0;
            do_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            co_q    <= co_d;
            do_q    <= do_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: request-to-send, bit shifting, ACK sampling, watchdog.
    always_comb begin
        // NOTE: every _d signal gets a default first so no latch can be inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        co_d    = co_q;
        do_d    = do_q;
        done_d  = 1'b0;
        err_d   = err_q;
        fail    = 1'b0;
`ifdef PS2TX_RESEND_EN
        retry_d = retry_q;
        data_d  = data_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                co_d = 1'b0;
                do_d = 1'b0;
                if (start) begin
                    shift_d = {~^di, di};
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    co_d    = 1'b1;
                    state_d = S_INHIB;
`ifdef PS2TX_RESEND_EN
                    retry_d = '0;
                    data_d  = di;
`endif
                end
            end
            // Host owns the bus here; device edges are ignored.
            S_INHIB: begin
                if (cnt_q == INH_LAST) begin
                    co_d    = 1'b0;
                    do_d    = 1'b1;          // start bit
                    cnt_d   = '0;
                    state_d = S_RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RTS: begin
                bit_d   = '0;
                cnt_d   = '0;
                state_d = S_XFER;
            end
            S_XFER: begin
                // An edge wins over a watchdog expiry in the same tick.
                if (fe) begin
                    cnt_d = '0;
                    bit_d = bit_q + 1'b1;
                    if (bit_q <= 4'd8) begin
                        do_d    = ~shift_q[0];   // data bits 0..7, then parity
                        shift_d = {1'b0, shift_q[8:1]};
                    end else if (bit_q == 4'd9) begin
                        do_d = 1'b0;             // stop bit: release data
                    end else begin
                        do_d    = 1'b0;
                        err_d   = d_s;           // data still high = NACK
                        state_d = S_WAITIDLE;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAITIDLE: begin
                if (c_s && d_s) begin
                    if (err_q) begin
                        fail = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                co_d    = 1'b0;
                do_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A failed attempt releases both lines, then either retries or reports.
        if (fail) begin
            co_d = 1'b0;
            do_d = 1'b0;
            if (can_retry) begin
`ifdef PS2TX_RESEND_EN
                retry_d = retry_q + 1'b1;
                shift_d = {~^data_q, data_q};
`endif
                err_d   = 1'b0;
                cnt_d   = '0;
                co_d    = 1'b1;
                state_d = S_INHIB;
            end else begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    assign ps2Co = co_q;
    assign ps2Do = do_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign error = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- randomized bench for ps2_host_tx with a behavioural PS/2 device.
// Stimulus pushes expected transactions; the device records frames off the wire;
// a monitor pops and compares on every done pulse.
module tb_ps2_host_tx;

    localparam int INHIBIT = 800;
    localparam int TIMEOUT = 16000;
    localparam int RETRIES = 2;
    localparam int HALF    = 20;   // device half clock period in ce ticks
`ifdef PS2TX_RESEND_EN
    localparam int ATTEMPTS = RETRIES + 1;
`else
    localparam int ATTEMPTS = 1;
`endif

    typedef enum logic [1:0] {M_ACK, M_NACK, M_STALL} mode_e;
    typedef struct {
        logic [7:0] data;
        mode_e      mode;
    } exp_t;
    typedef struct {
        logic [10:0] bits;   // bits[0] = start bit as seen on the wire
        int          n;      // number of bits sampled
    } frame_t;

    logic       clock;
    logic       reset;
    logic       ce;
    logic       ps2Ci, ps2Di;
    logic       ps2Co, ps2Do;
    logic       start;
    logic [7:0] di;
    logic       busy, done, error;
    logic       dev_c, dev_d;   // device pull-downs
    mode_e      dev_mode;

    exp_t   exp_q[$];
    frame_t frames_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     rts_cnt = 0;
    int     exp_rts = 0;
    int     fall_total = 0;
    int     last_fall = 0;
    int     tick_cnt = 0;
    int     cyc = 0;

    // Open-collector bus: low if either side pulls.
    assign ps2Ci = ~(ps2Co | dev_c);
    assign ps2Di = ~(ps2Do | dev_d);

    ps2_host_tx #(
        .INHIBIT(INHIBIT),
        .TIMEOUT(TIMEOUT),
        .RETRIES(RETRIES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ce   (ce),
        .ps2Ci(ps2Ci),
        .ps2Di(ps2Di),
        .ps2Co(ps2Co),
        .ps2Do(ps2Do),
        .start(start),
        .di   (di),
        .busy (busy),
        .done (done),
        .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ce high on three of every four clocks, changed well away from the edges.
    initial begin
        ce = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            cyc++;
            ce = ((cyc % 4) != 0);
        end
    end

    task automatic ce_tick();
        do @(negedge clock); while (ce !== 1'b1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: start 0, data LSB-first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    initial begin
        forever begin
            ce_tick();
            tick_cnt++;
        end
    end

    // Behavioural PS/2 device.
    initial begin : device
        frame_t f;
        int     inh;
        bit     abort;
        dev_c = 1'b0;
        dev_d = 1'b0;
        forever begin
            do ce_tick(); while (ps2Co !== 1'b1);
            inh = 0;
            while (ps2Co === 1'b1) begin
                inh++;
                ce_tick();
            end
            rts_cnt++;
            check("inhibit_ticks", inh, INHIBIT);
            check("rts_data_low", ps2Di, 1'b0);
            f.bits = '0;
            f.n    = 0;
            abort  = 1'b0;
            for (int k = 0; k < 11; k++) begin
                repeat (HALF) ce_tick();
                if (reset !== 1'b1) begin
                    abort = 1'b1;
                    break;
                end
                f.bits[k] = ps2Di;
                f.n++;
                if (dev_mode == M_STALL && k == 3) break;
                if (k == 10 && dev_mode == M_ACK) dev_d = 1'b1;
                repeat (2) ce_tick();
                dev_c = 1'b1;
                fall_total++;
                last_fall = tick_cnt;
                repeat (HALF) ce_tick();
                dev_c = 1'b0;
                if (reset !== 1'b1) begin
                    abort = 1'b1;
                    break;
                end
            end
            dev_c = 1'b0;
            if (!abort) frames_q.push_back(f);
            repeat (2) ce_tick();
            dev_d = 1'b0;
        end
    end

    // Monitor: every done pulse retires one expected transaction.
    initial begin : monitor
        exp_t        e;
        frame_t      f;
        logic [10:0] want;
        int          el;
        forever begin
            ce_tick();
            if (done === 1'b1) begin
                check("done_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("error_flag", error, e.mode != M_ACK);
                    check("busy_at_done", busy, 1'b0);
                    check("frame_count", frames_q.size(), (e.mode == M_ACK) ? 1 : ATTEMPTS);
                    want = model_frame(e.data);
                    while (frames_q.size() > 0) begin
                        f = frames_q.pop_front();
                        if (e.mode == M_STALL) begin
                            check("stall_bit_count", f.n, 4);
                            check("stall_frame", f.bits & 11'h00F, want & 11'h00F);
                        end else begin
                            check("frame_bits", f.bits, want);
                        end
                    end
                    if (e.mode == M_STALL) begin
                        el = tick_cnt - last_fall;
                        check("timeout_window", (el >= TIMEOUT) && (el <= TIMEOUT + 8), 1'b1);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [7:0] b, input mode_e m);
        exp_t e;
        e.data   = b;
        e.mode   = m;
        dev_mode = m;
        exp_q.push_back(e);
        exp_rts += (m == M_ACK) ? 1 : ATTEMPTS;
        di    = b;
        start = 1'b1;
        ce_tick();
        start = 1'b0;
        di    = 8'($urandom);
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        while (exp_q.size() > 0 && waited < 25000 * ATTEMPTS) begin
            ce_tick();
            waited++;
        end
        check("done_within_budget", exp_q.size(), 0);
        repeat (5) ce_tick();
    endtask

    task automatic send(input logic [7:0] b, input mode_e m);
        issue(b, m);
        wait_done();
    endtask

    initial begin : stimulus
        int    base;
        int    waited;
        mode_e m;
        reset    = 1'b0;
        start    = 1'b0;
        di       = 8'h00;
        dev_mode = M_ACK;
        repeat (5) ce_tick();
        check("reset_co", ps2Co, 1'b0);
        check("reset_do", ps2Do, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_error", error, 1'b0);
        reset = 1'b1;
        repeat (5) ce_tick();

        send(8'hED, M_ACK);
        send(8'h00, M_ACK);
        for (int i = 0; i < 6; i++) begin
            m = ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK;
            send(8'($urandom), m);
        end
        send(8'($urandom), M_NACK);

        // start while busy must be ignored
        issue(8'($urandom), M_ACK);
        base   = fall_total;
        waited = 0;
        while (fall_total < base + 2 && waited < 5000) begin
            ce_tick();
            waited++;
        end
        di    = 8'h55;
        start = 1'b1;
        repeat (3) ce_tick();
        start = 1'b0;
        wait_done();

        // reset in the middle of the frame (bit 3 is 0, so data is pulled low)
        dev_mode = M_ACK;
        exp_rts += 1;
        di    = 8'($urandom) & 8'hF7;
        start = 1'b1;
        ce_tick();
        start = 1'b0;
        base   = fall_total;
        waited = 0;
        while (fall_total < base + 4 && waited < 5000) begin
            ce_tick();
            waited++;
        end
        check("reached_bit4", fall_total - base, 4);
        repeat (5) ce_tick();
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_do", ps2Do, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_co", ps2Co, 1'b0);
        check("rst_mid_do", ps2Do, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        repeat (30) ce_tick();
        reset = 1'b1;
        repeat (40) ce_tick();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_co", ps2Co, 1'b0);
        check("post_rst_error", error, 1'b0);

        send(8'($urandom), M_ACK);
        send(8'($urandom), M_STALL);

        repeat (2000) ce_tick();
        check("rts_total", rts_cnt, exp_rts);
        check("queues_drained", exp_q.size() + frames_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
